// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the PC sequencer slice.
// Holds PC sizing, increment and default vectors.
package cpu_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_INCR = 32'd4;

    localparam logic [PC_WIDTH-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    function automatic logic misaligned(input logic [PC_WIDTH-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-side bundle between decode/branch logic and the PC sequencer.
// master drives requests, slave owns the PC.
interface pc_sequencer_if;
    import cpu_pkg::*;

    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                jump;
    logic [PC_WIDTH-1:0] jump_target;
    logic                halt;
    logic                resume;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                pc_valid;
    logic                halted;
    logic                misalign_trap;

    modport master (
        output stall, branch_taken, branch_target,
        output jump, jump_target, halt, resume,
        input  pc, pc_plus4, pc_valid, halted, misalign_trap
    );

    modport slave (
        input  stall, branch_taken, branch_target,
        input  jump, jump_target, halt, resume,
        output pc, pc_plus4, pc_valid, halted, misalign_trap
    );

endinterface

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC priority select for the RUN state.
// Misaligned-target trap check under PC_MISALIGN_TRAP_EN.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] pc_plus4,
    input  logic                stall,
    input  logic                halt,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                trap
);

    // Priority: stall, halt, jump, branch, sequential
    always_comb begin
        next_pc = pc_plus4;
        trap    = 1'b0;
        priority case (1'b1)
            stall, halt:  next_pc = pc;
            jump:         next_pc = jump_target;
            branch_taken: next_pc = branch_target;
            default:      next_pc = pc_plus4;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        if (!stall && !halt && (jump || branch_taken)
            && misaligned(next_pc)) begin
            next_pc = TRAP_VECTOR;
            trap    = 1'b1;
        end
`endif
    end

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VECTOR;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program counter register, boot hold and BOOT/RUN/HALT control.
// Optional misaligned-target trap: define PC_MISALIGN_TRAP_EN.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned         BOOT_CYCLES  = 4,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam logic [1:0] S_BOOT = BOOT;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_HALT = HALT;

    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

    logic [1:0]          state;
    logic [7:0]          boot_cnt;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] next_pc;
    logic                mux_trap;
    logic                valid_q;
    logic                halted_q;

    // Sequential address wraps silently at the top of memory
    assign pc_inc = pc_q + PC_INCR;

    pc_next_mux #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_mux (
        .pc            (pc_q),
        .pc_plus4      (pc_inc),
        .stall         (bus.stall),
        .halt          (bus.halt),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .next_pc       (next_pc),
        .trap          (mux_trap)
    );

    // FSM, PC register and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            boot_cnt <= 8'd0;
            pc_q     <= RESET_VECTOR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state   <= S_RUN;
                        valid_q <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    if (bus.stall) begin
                        state <= S_RUN;
                    end else if (bus.halt) begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                        valid_q  <= 1'b0;
                    end else begin
                        pc_q <= next_pc;
                    end
                end
                S_HALT: begin
                    if (bus.resume) begin
                        pc_q     <= pc_inc;
                        state    <= S_RUN;
                        halted_q <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_BOOT;
                    boot_cnt <= 8'd0;
                    pc_q     <= RESET_VECTOR;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q;

    // One-cycle pulse alongside the PC load to the trap vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= (state == S_RUN) && !bus.stall
                      && !bus.halt && mux_trap;
        end
    end

    assign bus.misalign_trap = trap_q;
`else
    logic unused_mux_trap;
    assign unused_mux_trap   = mux_trap;
    assign bus.misalign_trap = 1'b0;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_inc;
    assign bus.pc_valid = valid_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, redirects, stall,
// halt/resume, wrap, mid-run reset and misaligned targets.
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .BOOT_CYCLES  (4),
        .TRAP_VECTOR  (32'h0000_0080)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        bus.jump = 1'b0;
        bus.jump_target = '0;
        bus.halt = 1'b0;
        bus.resume = 1'b0;

        step();
        step();
        check("rst_pc", bus.pc, 32'h0);
        check("rst_valid", 32'(bus.pc_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_trap", 32'(bus.misalign_trap), 32'd0);

        // Boot hold: three edges still invalid, fourth raises pc_valid
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("boot_pc", bus.pc, 32'h0);
            check("boot_valid", 32'(bus.pc_valid), 32'd0);
        end
        step();
        check("boot4_pc", bus.pc, 32'h0);
        check("boot4_valid", 32'(bus.pc_valid), 32'd1);
        step();
        check("seq_4", bus.pc, 32'h4);
        step();
        check("seq_8", bus.pc, 32'h8);
        step();
        step();
        check("seq_10", bus.pc, 32'h10);

        // jump beats branch
        bus.jump = 1'b1;
        bus.jump_target = 32'h200;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h300;
        step();
        check("jump_wins", bus.pc, 32'h200);
        bus.jump = 1'b0;
        bus.branch_target = 32'h40;
        step();
        check("branch", bus.pc, 32'h40);

        // Stall freezes pc with branch held
        bus.stall = 1'b1;
        bus.branch_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", bus.pc, 32'h40);
        end
        bus.stall = 1'b0;
        step();
        check("stall_release", bus.pc, 32'h100);

        bus.branch_target = 32'h20;
        step();
        check("to_20", bus.pc, 32'h20);
        bus.branch_taken = 1'b0;

        // Halt with jump asserted throughout
        bus.halt = 1'b1;
        bus.jump = 1'b1;
        bus.jump_target = 32'h500;
        step();
        check("halt_pc", bus.pc, 32'h20);
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_valid", 32'(bus.pc_valid), 32'd0);
        bus.halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_hold", bus.pc, 32'h20);
            check("halt_stay", 32'(bus.halted), 32'd1);
        end
        bus.jump = 1'b0;
        bus.halt = 1'b1;
        bus.resume = 1'b1;
        step();
        check("resume_pc", bus.pc, 32'h24);
        check("resume_halted", 32'(bus.halted), 32'd0);
        check("resume_valid", 32'(bus.pc_valid), 32'd1);
        bus.halt = 1'b0;
        bus.resume = 1'b0;

        // Wrap at top of address space
        bus.jump = 1'b1;
        bus.jump_target = 32'hFFFF_FFFC;
        step();
        check("top_pc", bus.pc, 32'hFFFF_FFFC);
        check("top_plus4", bus.pc_plus4, 32'h0);
        bus.jump = 1'b0;
        step();
        check("wrap_pc", bus.pc, 32'h0);

        // Misaligned jump target
        bus.jump = 1'b1;
        bus.jump_target = 32'h102;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc", bus.pc, 32'h80);
        check("mis_trap", 32'(bus.misalign_trap), 32'd1);
`else
        check("mis_pc", bus.pc, 32'h102);
        check("mis_trap", 32'(bus.misalign_trap), 32'd0);
`endif
        bus.jump = 1'b0;
        step();
        check("mis_trap_end", 32'(bus.misalign_trap), 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_next", bus.pc, 32'h84);
`else
        check("mis_next", bus.pc, 32'h106);
`endif

        // Reset in the middle of RUN
        rst_n = 1'b0;
        step();
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_valid", 32'(bus.pc_valid), 32'd0);
        check("mid_rst_halted", 32'(bus.halted), 32'd0);
        rst_n = 1'b1;
        step();
        check("reboot_pc", bus.pc, 32'h0);
        check("reboot_valid", 32'(bus.pc_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and decides its next value each cycle for the single-cycle CPU.
- Selects between sequential fetch (PC+4), branch target, and jump target.
- Adds a boot-hold period, pipeline stall, and a HALT/RESUME state machine.
- Sits between the control/branch-compare logic and instruction memory; its pc output drives the instruction memory address directly.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- BOOT_CYCLES, 4, cycles the PC is held at RESET_VECTOR after reset release. Range 1..255.
- TRAP_VECTOR, 32'h0000_0080, redirect target for a misaligned target. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  freeze PC this cycle.
- branch_taken  in  1  take branch_target at the next edge.
- branch_target  in  32  branch destination.
- jump  in  1  take jump_target at the next edge.
- jump_target  in  32  jump destination.
- halt  in  1  halt instruction decoded at the current pc.
- resume  in  1  leave HALT.
- pc  out  32  current PC, registered.
- pc_plus4  out  32  combinational pc + 4.
- pc_valid  out  1  registered; 1 when pc addresses an instruction to execute.
- halted  out  1  registered; 1 in HALT.
- misalign_trap  out  1  registered one-cycle pulse. Driven only with the optional feature; tied 0 otherwise.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled only at the rising edge of clk.
- Reset values, while rst_n=0 at an edge:
  - pc = RESET_VECTOR
  - pc_valid = 0
  - halted = 0
  - misalign_trap = 0
  - state = BOOT
  - boot counter = 0
- Reset mid-operation (any state) behaves identically.
- State machine, 2-bit encoding (BOOT, RUN, HALT):
  - BOOT: pc held. Counter increments each edge. When the counter reaches BOOT_CYCLES-1: next state RUN, pc_valid=1 at that edge. pc stays RESET_VECTOR, so the first executed instruction is at RESET_VECTOR. All other inputs are ignored in BOOT.
  - RUN: next-pc priority per edge:
    1. stall=1: pc and state unchanged; redirects ignored. Requesters must hold branch/jump until stall drops.
    2. halt=1: pc unchanged; next state HALT; halted=1; pc_valid=0.
    3. jump=1: pc = jump_target.
    4. branch_taken=1: pc = branch_target.
    5. else: pc = pc_plus4.
  - jump and branch_taken together: jump wins.
  - HALT: pc frozen; stall, branch and jump ignored. With resume=1: pc = pc_plus4, state RUN, halted=0, pc_valid=1. halt and resume together in HALT: resume wins.
- Arithmetic: pc_plus4 is a 32-bit modulo add. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Latency: a redirect presented in cycle N is visible on pc after the edge ending cycle N (one cycle).
- Targets are not checked for alignment unless the optional feature is compiled in.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- When defined: in RUN, an accepted jump or branch whose target[1:0]≠0 loads pc=TRAP_VECTOR and pulses misalign_trap for one cycle (asserted the same edge pc updates). State stays RUN.
- When undefined: targets are loaded verbatim and misalign_trap is constant 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the pc_state_t enum (BOOT, RUN, HALT)
  - the PC_WIDTH=32 constant
  - the PC_INCR=4 constant
  - default RESET_VECTOR and TRAP_VECTOR constants
- One natural sub-module: pc_next_mux, the combinational priority selection of the next PC (including the trap check). The FSM and registers stay in pc_sequencer.

Test Plan:
- Boot hold: rst_n=0 for 2 cycles, then 1 with BOOT_CYCLES=4 → pc=0 for 4 edges; pc_valid rises on the 4th edge. Next edge pc=4, then 8.
- Redirect priority: in RUN at pc=0x10, jump=1 (0x200) and branch_taken=1 (0x300) → pc=0x200. Next cycle branch_taken=1 (0x40) alone → pc=0x40.
- Stall: pc=0x40, stall=1 for 3 cycles with branch_taken=1 (0x100) → pc stays 0x40. When stall drops with branch still high → pc=0x100.
- Halt/resume: halt=1 at pc=0x20 → halted=1, pc_valid=0, pc=0x20 held 5 cycles despite jump=1. resume=1 → pc=0x24, halted=0, pc_valid=1.
- Wrap and reset mid-run: pc=0xFFFF_FFFC, no redirect → pc=0. Then rst_n=0 in RUN → pc=RESET_VECTOR, state BOOT, pc_valid=0 after that edge.
- PC_MISALIGN_TRAP_EN defined: jump_target=0x102 → pc=0x80, misalign_trap=1 for exactly one cycle. Without the macro → pc=0x102, misalign_trap=0.
